// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller and its period timer.
// Holds the ramp state encoding and the default duty/period widths that
// must agree with the downstream PWM generator.
package pwm_ctrl_pkg;

    localparam int PWM_WIDTH       = 10;
    localparam int PWM_PERIOD_LOG2 = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        WAIT = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter. Raises period_tick for one clock on the
// last count of every period, so duty updates can land exactly on a
// period boundary.
module pwm_period_timer
    import pwm_ctrl_pkg::*;
#(
    parameter int PERIOD_LOG2 = PWM_PERIOD_LOG2
) (
    input  logic clk,
    input  logic reset_n,
    output logic period_tick
);

    logic [PERIOD_LOG2-1:0] count;

    // Count clocks continuously, wrapping at the end of each PWM period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count + PERIOD_LOG2'(1);
        end
    end

    assign period_tick = (count == '1);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Slew-rate limiter in front of the PWM generator's duty input.
// Accepts a duty target over valid/ready and walks `set` toward it by at
// most `step` per PWM period, with `hold` extra periods between steps.
// Duty only changes on the edge that ends a period, so the generator never
// sees a mid-period change.
// Optional feature: define PWM_RAMP_ESTOP_EN to add the `estop` input,
// which forces the duty to 0 immediately and blocks new targets.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int PERIOD_LOG2 = PWM_PERIOD_LOG2,
    parameter int HOLD_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     target,
    input  logic                 target_valid,
    output logic                 target_ready,
    input  logic [WIDTH-1:0]     step,
    input  logic [HOLD_BITS-1:0] hold,
`ifdef PWM_RAMP_ESTOP_EN
    input  logic                 estop,
`endif
    output logic [WIDTH-1:0]     set,
    output logic                 busy,
    output logic                 at_target,
    output logic                 period_tick
);

    ramp_state_t          state;
    logic [WIDTH-1:0]     goal;
    logic [HOLD_BITS-1:0] holdcnt;
    logic [WIDTH-1:0]     step_result;
    logic [WIDTH-1:0]     goal_next;
    logic                 accept;
    logic                 estop_active;

`ifdef PWM_RAMP_ESTOP_EN
    assign estop_active = estop;
`else
    assign estop_active = 1'b0;
`endif

    assign target_ready = !estop_active;
    assign accept       = target_valid && target_ready;
    assign goal_next    = accept ? target : goal;
    assign busy         = (state != IDLE);
    assign at_target    = (state == IDLE);

    pwm_period_timer #(
        .PERIOD_LOG2 (PERIOD_LOG2)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .period_tick (period_tick)
    );

    // Next duty for a step toward the current goal, clamped so it never overshoots.
    always_comb begin
        step_result = goal;
        if (step != '0) begin
            if (goal > set) begin
                if ((goal - set) > step) begin
                    step_result = set + step;
                end
            end else if ((set - goal) > step) begin
                step_result = set - step;
            end
        end
    end

    // Ramp state machine: goal capture, period-aligned stepping and hold countdown.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            set     <= '0;
            goal    <= '0;
            holdcnt <= '0;
        end else if (estop_active) begin
            state   <= IDLE;
            set     <= '0;
            goal    <= '0;
            holdcnt <= '0;
        end else begin
            if (accept) begin
                goal <= target;
            end
            case (state)
                IDLE: begin
                    if (accept && (target != set)) begin
                        state <= RAMP;
                    end
                end
                RAMP: begin
                    if (period_tick) begin
                        set <= step_result;
                        if (step_result == goal_next) begin
                            state <= IDLE;
                        end else if (hold != '0) begin
                            holdcnt <= hold;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (accept && (target == set)) begin
                        state   <= IDLE;
                        holdcnt <= '0;
                    end else if (period_tick) begin
                        holdcnt <= holdcnt - HOLD_BITS'(1);
                        if (holdcnt == HOLD_BITS'(1)) begin
                            state <= RAMP;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl with a 16-clock PWM period.
// Directed ramp scenarios come from a vector table, corner cases are
// hand-written, and a randomized phase is compared against a behavioural
// model. Define PWM_RAMP_ESTOP_EN to also exercise the emergency stop.
module tb_pwm_ramp_ctrl;

    localparam int WIDTH       = 10;
    localparam int PERIOD_LOG2 = 4;
    localparam int HOLD_BITS   = 4;
    localparam int PERIOD      = 16;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [WIDTH-1:0]     target = '0;
    logic                 target_valid = 1'b0;
    logic                 target_ready;
    logic [WIDTH-1:0]     step = '0;
    logic [HOLD_BITS-1:0] hold = '0;
    logic                 estop = 1'b0;
    logic [WIDTH-1:0]     set;
    logic                 busy;
    logic                 at_target;
    logic                 period_tick;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural reference: duty, goal, ramp activity and periods still to skip.
    int mCnt    = 0;
    int mSet    = 0;
    int mGoal   = 0;
    bit mActive = 1'b0;
    int mWait   = 0;

    typedef struct {
        bit    acc;
        int    tgt;
        int    stp;
        int    hld;
        int    ticks;
        int    expSet;
        bit    expBusy;
        string name;
    } vec_t;

    vec_t vecs[$];

    pwm_ramp_ctrl #(
        .WIDTH       (WIDTH),
        .PERIOD_LOG2 (PERIOD_LOG2),
        .HOLD_BITS   (HOLD_BITS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .step         (step),
        .hold         (hold),
`ifdef PWM_RAMP_ESTOP_EN
        .estop        (estop),
`endif
        .set          (set),
        .busy         (busy),
        .at_target    (at_target),
        .period_tick  (period_tick)
    );

    always #5 clk = ~clk;

    function automatic int moveToward(input int cur, input int dst, input int stp);
        int diff;
        diff = dst - cur;
        if (stp == 0 || (diff <= stp && diff >= -stp)) return dst;
        return (diff > 0) ? cur + stp : cur - stp;
    endfunction

    // Reference model advances once per clock edge from the driven inputs.
    always @(posedge clk or negedge reset_n) begin
        bit tick;
        int newGoal;
        if (!reset_n) begin
            mCnt = 0; mSet = 0; mGoal = 0; mActive = 1'b0; mWait = 0;
        end else begin
            tick = (mCnt == PERIOD - 1);
            if (estop) begin
                mSet = 0; mGoal = 0; mActive = 1'b0; mWait = 0;
            end else begin
                newGoal = target_valid ? int'(target) : mGoal;
                if (!mActive) begin
                    if (target_valid && int'(target) != mSet) mActive = 1'b1;
                end else if (mWait > 0) begin
                    if (target_valid && int'(target) == mSet) begin
                        mActive = 1'b0;
                        mWait   = 0;
                    end else if (tick) begin
                        mWait = mWait - 1;
                    end
                end else if (tick) begin
                    mSet = moveToward(mSet, mGoal, int'(step));
                    if (mSet == newGoal) mActive = 1'b0;
                    else mWait = int'(hold);
                end
                mGoal = newGoal;
            end
            mCnt = (mCnt + 1) % PERIOD;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Offer one target for a single non-tick cycle.
    task automatic applyStimulus(input int tgt);
        if (mCnt == PERIOD - 1) @(negedge clk);
        target       = WIDTH'(tgt);
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    // Advance to just past the next period-ending edge.
    task automatic waitTick();
        for (int c = 0; c < 3 * PERIOD; c++) begin
            if (mCnt == PERIOD - 1) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checkOutput("tick timeout", 0, 1);
    endtask

    task automatic checkIdle(input string name, input int expSet);
        checkOutput({name, " set"}, int'(set), expSet);
        checkOutput({name, " busy"}, int'(busy), 0);
        checkOutput({name, " at_target"}, int'(at_target), 1);
    endtask

    initial begin
        int gap;

        vecs.push_back('{1'b1, 100, 25, 0, 1, 25, 1'b1, "up25 s1"});
        vecs.push_back('{1'b0, 100, 25, 0, 1, 50, 1'b1, "up25 s2"});
        vecs.push_back('{1'b0, 100, 25, 0, 1, 75, 1'b1, "up25 s3"});
        vecs.push_back('{1'b0, 100, 25, 0, 1, 100, 1'b0, "up25 s4"});
        vecs.push_back('{1'b1, 10, 40, 0, 1, 60, 1'b1, "down40 s1"});
        vecs.push_back('{1'b0, 10, 40, 0, 1, 20, 1'b1, "down40 s2"});
        vecs.push_back('{1'b0, 10, 40, 0, 1, 10, 1'b0, "down40 clamp"});
        vecs.push_back('{1'b1, 0, 0, 0, 1, 0, 1'b0, "jump to 0"});
        vecs.push_back('{1'b1, 100, 50, 2, 1, 50, 1'b1, "hold2 t1"});
        vecs.push_back('{1'b0, 100, 50, 2, 1, 50, 1'b1, "hold2 t2"});
        vecs.push_back('{1'b0, 100, 50, 2, 1, 50, 1'b1, "hold2 t3"});
        vecs.push_back('{1'b0, 100, 50, 2, 1, 100, 1'b0, "hold2 t4"});
        vecs.push_back('{1'b1, 1023, 0, 0, 1, 1023, 1'b0, "step0 jump"});
        vecs.push_back('{1'b1, 1023, 0, 0, 0, 1023, 1'b0, "same target"});
        vecs.push_back('{1'b0, 1023, 0, 0, 1, 1023, 1'b0, "same target tick"});
        vecs.push_back('{1'b1, 0, 0, 0, 1, 0, 1'b0, "back to 0"});
        vecs.push_back('{1'b1, 100, 25, 0, 1, 25, 1'b1, "retarget r1"});
        vecs.push_back('{1'b0, 100, 25, 0, 1, 50, 1'b1, "retarget r2"});
        vecs.push_back('{1'b1, 0, 25, 0, 1, 25, 1'b1, "retarget r3"});
        vecs.push_back('{1'b0, 0, 25, 0, 1, 0, 1'b0, "retarget r4"});

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        checkIdle("reset", 0);
        checkOutput("reset ready", int'(target_ready), 1);
        checkOutput("reset tick", int'(period_tick), 0);
        reset_n = 1'b1;

        // First tick 15 clocks after release, then every 16 clocks.
        gap = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (period_tick) begin gap = i; break; end
        end
        checkOutput("first tick", gap, 15);
        gap = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (period_tick) begin gap = i; break; end
        end
        checkOutput("tick period", gap, 16);

        // Table-driven ramp scenarios.
        foreach (vecs[i]) begin
            step = WIDTH'(vecs[i].stp);
            hold = HOLD_BITS'(vecs[i].hld);
            if (vecs[i].acc) applyStimulus(vecs[i].tgt);
            for (int k = 0; k < vecs[i].ticks; k++) waitTick();
            checkOutput({vecs[i].name, " set"}, int'(set), vecs[i].expSet);
            checkOutput({vecs[i].name, " busy"}, int'(busy), int'(vecs[i].expBusy));
            checkOutput({vecs[i].name, " at_target"}, int'(at_target), int'(!vecs[i].expBusy));
        end
        checkOutput("table ready", int'(target_ready), 1);

        // Accept landing on a tick cycle: that edge still steps toward the old goal.
        step = 10'd25;
        hold = '0;
        applyStimulus(100);
        waitTick();
        checkOutput("ontick pre set", int'(set), 25);
        for (int c = 0; c < 2 * PERIOD; c++) begin
            if (mCnt == PERIOD - 1) break;
            @(negedge clk);
        end
        target       = 10'd0;
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
        checkOutput("ontick old goal set", int'(set), 50);
        checkOutput("ontick old goal busy", int'(busy), 1);
        waitTick();
        checkOutput("ontick new goal set", int'(set), 25);
        waitTick();
        checkIdle("ontick done", 0);

        // Accept in WAIT whose target equals the current duty ends the ramp at once.
        step = 10'd30;
        hold = 4'd3;
        applyStimulus(100);
        waitTick();
        checkOutput("wait s1 set", int'(set), 30);
        checkOutput("wait s1 busy", int'(busy), 1);
        applyStimulus(30);
        checkIdle("wait equal", 30);
        waitTick();
        checkIdle("wait equal tick", 30);

`ifdef PWM_RAMP_ESTOP_EN
        // Emergency stop mid-ramp drops the duty on the next edge and stays down.
        step = 10'd10;
        hold = '0;
        applyStimulus(1000);
        waitTick();
        checkOutput("estop pre set", int'(set), 40);
        estop = 1'b1;
        #1;
        checkOutput("estop ready", int'(target_ready), 0);
        @(negedge clk);
        checkIdle("estop", 0);
        estop = 1'b0;
        waitTick();
        checkIdle("estop release", 0);
        checkOutput("estop release ready", int'(target_ready), 1);
`endif

        // Reset mid-ramp returns everything to reset values immediately.
        step = 10'd10;
        hold = '0;
        applyStimulus(1000);
        waitTick();
        waitTick();
        checkOutput("midramp busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        checkIdle("midramp reset", 0);
        checkOutput("midramp reset tick", int'(period_tick), 0);
        checkOutput("midramp reset ready", int'(target_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            target_valid = ($urandom_range(0, 11) == 0);
            target = ($urandom_range(0, 4) == 0) ? WIDTH'(mSet) : WIDTH'($urandom_range(0, 1023));
            step = ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom_range(1, 300));
            hold = HOLD_BITS'($urandom_range(0, 3));
`ifdef PWM_RAMP_ESTOP_EN
            estop = ($urandom_range(0, 150) == 0);
`endif
            @(negedge clk);
            checkOutput("rand set", int'(set), mSet);
            checkOutput("rand busy", int'(busy), int'(mActive));
            checkOutput("rand at_target", int'(at_target), int'(!mActive));
            checkOutput("rand tick", int'(period_tick), int'(mCnt == PERIOD - 1));
            checkOutput("rand ready", int'(target_ready), int'(!estop));
        end
        target_valid = 1'b0;
        estop        = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
